// File: rtl/mac_pkg.sv
// Shared widths and arithmetic helpers for the K x K convolution MAC.
package mac_pkg;

  // Widest accumulator the saturating adder supports (ACCW must stay below this).
  localparam int unsigned MAX_W = 64;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Exact width of one unsigned-pixel x signed-weight product.
  function automatic int unsigned prod_w(input int unsigned dw, input int unsigned ww);
    return dw + 1 + ww;
  endfunction

  // Exact width of the full K*K window dot-product.
  function automatic int unsigned sum_w(input int unsigned k, input int unsigned dw,
                                        input int unsigned ww);
    return prod_w(dw, ww) + clog2(k * k);
  endfunction

  // Signed add clamped to an accw-bit range; returns {sat_flag, clamped sum}.
  function automatic logic [MAX_W:0] sat_add(input logic signed [MAX_W-1:0] a,
                                             input logic signed [MAX_W-1:0] b,
                                             input int unsigned accw);
    logic signed [MAX_W:0] s;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    s  = {a[MAX_W-1], a} + {b[MAX_W-1], b};
    hi = $signed(((MAX_W+1)'(1) << (accw - 1)) - (MAX_W+1)'(1));
    lo = ~hi;
    if (s > hi)      return {1'b1, hi[MAX_W-1:0]};
    else if (s < lo) return {1'b1, lo[MAX_W-1:0]};
    else             return {1'b0, s[MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/mac_row_k.sv
// One window row: K multipliers (registered, S1) and a row adder (registered, S2).
module mac_row_k
  import mac_pkg::*;
#(
  parameter int unsigned K  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned WW = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [K*DW-1:0]                            pix,
  input  logic [K*WW-1:0]                            wt,
  output logic signed [prod_w(DW, WW)+clog2(K)-1:0]  row_sum
);

  localparam int unsigned PW = prod_w(DW, WW);
  localparam int unsigned RW = PW + clog2(K);

  logic signed [PW-1:0] prod_q [K];
  logic signed [RW-1:0] sum_c;

  // S1: exact signed products, pixel zero-extended to make it non-negative
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(K); c++) prod_q[c] <= '0;
    end else begin
      for (int c = 0; c < int'(K); c++)
        prod_q[c] <= PW'($signed({1'b0, pix[c*DW +: DW]})) * PW'($signed(wt[c*WW +: WW]));
    end
  end

  // Row adder over the K registered products
  always_comb begin
    sum_c = '0;
    for (int c = 0; c < int'(K); c++) sum_c = sum_c + RW'(prod_q[c]);
  end

  // S2: registered row sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) row_sum <= '0;
    else     row_sum <= sum_c;
  end

endmodule

// File: rtl/mac_kxk_acc.sv
// K x K convolution MAC with per-group channel accumulation, bias, saturation and ReLU.
module mac_kxk_acc
  import mac_pkg::*;
#(
  parameter int unsigned K    = 3,
  parameter int unsigned DW   = 8,
  parameter int unsigned WW   = 8,
  parameter int unsigned ACCW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [K*K*DW-1:0]    win,
  input  logic [K*K*WW-1:0]    weight,
  input  logic [ACCW-1:0]      bias,
  input  logic                 relu_en,
  output logic                 out_valid,
  output logic [ACCW-1:0]      out_data,
  output logic                 out_sat
);

  localparam int unsigned PW   = prod_w(DW, WW);
  localparam int unsigned RW   = PW + clog2(K);
  localparam int unsigned SW   = sum_w(K, DW, WW);
  localparam int unsigned PIPE = 3;

  logic signed [RW-1:0]   row_sum [K];
  logic signed [SW-1:0]   tot_c;
  logic signed [SW-1:0]   tot_q;

  logic [PIPE-1:0]        vld_q;
  logic [PIPE-1:0]        first_q;
  logic [PIPE-1:0]        last_q;
  logic [PIPE-1:0]        relu_q;
  logic [ACCW-1:0]        bias_q [PIPE];

  logic signed [ACCW-1:0] acc_q;
  logic                   sat_q;
  logic [MAX_W:0]         add_c;
  logic signed [ACCW-1:0] acc_d_c;
  logic                   sat_now_c;
  logic                   sat_d_c;

  // One row unit per kernel row covers S1 and S2
  for (genvar r = 0; r < int'(K); r++) begin : g_row
    mac_row_k #(.K(K), .DW(DW), .WW(WW)) u_row (
      .clk     (clk),
      .rst     (rst),
      .pix     (win[r*K*DW +: K*DW]),
      .wt      (weight[r*K*WW +: K*WW]),
      .row_sum (row_sum[r])
    );
  end

  // Sideband travels with the data; flags are qualified by valid on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      relu_q  <= '0;
      for (int i = 0; i < int'(PIPE); i++) bias_q[i] <= '0;
    end else begin
      vld_q   <= {vld_q[PIPE-2:0],   in_valid};
      first_q <= {first_q[PIPE-2:0], in_valid & in_first};
      last_q  <= {last_q[PIPE-2:0],  in_valid & in_last};
      relu_q  <= {relu_q[PIPE-2:0],  relu_en};
      bias_q[0] <= bias;
      for (int i = 1; i < int'(PIPE); i++) bias_q[i] <= bias_q[i-1];
    end
  end

  // Row tree over the K registered row sums
  always_comb begin
    tot_c = '0;
    for (int r = 0; r < int'(K); r++) tot_c = tot_c + SW'(row_sum[r]);
  end

  // S3: registered window total
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tot_q <= '0;
    else     tot_q <= tot_c;
  end

  // Saturating accumulate; a first beat restarts from bias and clears the sticky flag
  always_comb begin
    add_c = sat_add(first_q[PIPE-1] ? MAX_W'($signed(bias_q[PIPE-1])) : MAX_W'(acc_q),
                    MAX_W'(tot_q), ACCW);
    acc_d_c = add_c[ACCW-1:0];
    // Clamped result is a pure sign extension above ACCW; any disagreement is overflow too
    sat_now_c = add_c[MAX_W] | (add_c[MAX_W-1:ACCW] != {(MAX_W-ACCW){add_c[ACCW-1]}});
    sat_d_c   = first_q[PIPE-1] ? sat_now_c : (sat_q | sat_now_c);
  end

  // S4: accumulator, sticky flag and post-processed output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= vld_q[PIPE-1] & last_q[PIPE-1];
      if (vld_q[PIPE-1]) begin
        acc_q <= acc_d_c;
        sat_q <= sat_d_c;
        if (last_q[PIPE-1]) begin
          out_data <= (relu_q[PIPE-1] && acc_d_c[ACCW-1]) ? '0 : acc_d_c;
          out_sat  <= sat_d_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_kxk_acc.sv
// Directed bench for mac_kxk_acc: a 32-bit and a 16-bit accumulator instance share stimulus.
module tb_mac_kxk_acc;

  localparam int unsigned K    = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned WW   = 8;
  localparam int unsigned NT   = K * K;
  localparam int unsigned ACCW = 32;
  localparam int unsigned AW16 = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_first, in_last, relu_en;
  logic [NT*DW-1:0] win;
  logic [NT*WW-1:0] weight;
  logic signed [ACCW-1:0] bias;
  logic signed [AW16-1:0] bias16;
  logic out_valid, out_sat, out_valid16, out_sat16;
  logic signed [ACCW-1:0] out_data;
  logic signed [AW16-1:0] out_data16;

  assign bias16 = bias[AW16-1:0];

  always #5 clk = ~clk;

  mac_kxk_acc #(.K(K), .DW(DW), .WW(WW), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .win(win), .weight(weight), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
  );

  mac_kxk_acc #(.K(K), .DW(DW), .WW(WW), .ACCW(AW16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .win(win), .weight(weight), .bias(bias16), .relu_en(relu_en),
    .out_valid(out_valid16), .out_data(out_data16), .out_sat(out_sat16)
  );

  typedef struct {
    int     pix;
    int     wt;
    bit     full;
    int     bi;
    bit     relu;
    longint exp32;
    bit     sat32;
    longint exp16;
    bit     sat16;
  } vec_t;

  vec_t tv [6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;

  logic signed [ACCW-1:0] vq [$];
  logic                   sq [$];
  int                     cq [$];
  logic signed [AW16-1:0] vq16 [$];
  logic                   sq16 [$];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    vq.delete(); sq.delete(); cq.delete(); vq16.delete(); sq16.delete();
  endtask

  // Advance one edge and record any result pulses from both instances
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      vq.push_back(out_data); sq.push_back(out_sat); cq.push_back(cyc);
    end
    if (out_valid16 === 1'b1) begin
      vq16.push_back(out_data16); sq16.push_back(out_sat16);
    end
  endtask

  task automatic drive(input bit first, input bit last, input int bi, input bit relu);
    in_valid = 1'b1; in_first = first; in_last = last;
    bias = ACCW'(bi); relu_en = relu;
    step();
  endtask

  // Tap 0 only, or every tap, carries pix/wt
  task automatic beat(input int pix, input int wt, input bit full, input bit first,
                      input bit last, input int bi, input bit relu);
    win = '0; weight = '0;
    for (int t = 0; t < int'(NT); t++)
      if (full || t == 0) begin
        win[t*DW +: DW]    = DW'(pix);
        weight[t*WW +: WW] = WW'(wt);
      end
    drive(first, last, bi, relu);
  endtask

  // Bubble with flags set and a non-zero window; all of it must be ignored
  task automatic idle_beat();
    in_valid = 1'b0; in_first = 1'b1; in_last = 1'b1;
    win = '1; weight = {NT{8'h01}};
    step();
  endtask

  task automatic check_one(input string name, input longint exp, input int at);
    chk({name, " count"}, 64'(vq.size()), 64'sd1);
    if (vq.size() >= 1) begin
      chk({name, " data"}, 64'(vq[0]), exp);
      chk({name, " cycle"}, 64'(cq[0]), 64'(at));
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; relu_en = 1'b0;
    win = '0; weight = '0; bias = '0;

    //          pix  wt  full bias relu exp32   sat exp16   sat
    tv[0] = '{255, -128, 1'b1,   0, 1'b0, -293760, 1'b0, -32768, 1'b1};
    tv[1] = '{ 50,   -1, 1'b0,   0, 1'b1,       0, 1'b0,      0, 1'b0};
    tv[2] = '{ 50,   -1, 1'b0,   0, 1'b0,     -50, 1'b0,    -50, 1'b0};
    tv[3] = '{ 10,    1, 1'b0,  -3, 1'b1,       7, 1'b0,      7, 1'b0};
    tv[4] = '{255,  127, 1'b1, 100, 1'b1,  291565, 1'b0,  32767, 1'b1};
    tv[5] = '{255, -128, 1'b1,   0, 1'b1,       0, 1'b0,      0, 1'b1};

    #1 rst = 1'b1;
    #1;
    chk("reset out_valid", 64'(out_valid), 64'sd0);
    chk("reset out_data", 64'(out_data), 64'sd0);
    chk("reset out_sat", 64'(out_sat), 64'sd0);
    chk("reset out_data16", 64'(out_data16), 64'sd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single-beat groups from the table
    for (int i = 0; i < 6; i++) begin
      clear_q();
      c0 = cyc;
      beat(tv[i].pix, tv[i].wt, tv[i].full, 1'b1, 1'b1, tv[i].bi, tv[i].relu);
      repeat (5) idle_beat();
      check_one($sformatf("tv%0d", i), tv[i].exp32, c0 + 4);
      if (sq.size() >= 1) chk($sformatf("tv%0d sat", i), 64'(sq[0]), 64'(tv[i].sat32));
      chk($sformatf("tv%0d count16", i), 64'(vq16.size()), 64'sd1);
      if (vq16.size() >= 1) begin
        chk($sformatf("tv%0d data16", i), 64'(vq16[0]), tv[i].exp16);
        chk($sformatf("tv%0d sat16", i), 64'(sq16[0]), 64'(tv[i].sat16));
      end
    end

    // Three-beat group 10, 20, -5 with bias 100
    clear_q();
    beat(10, 1, 1'b0, 1'b1, 1'b0, 100, 1'b0);
    beat(20, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    c0 = cyc;
    beat(5, -1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    check_one("grp3", 125, c0 + 4);

    // Same group with a bubble inside
    clear_q();
    beat(10, 1, 1'b0, 1'b1, 1'b0, 100, 1'b0);
    idle_beat();
    beat(20, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    c0 = cyc;
    beat(5, -1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    check_one("grp3 bubble", 125, c0 + 4);

    // in_first mid-group restarts from the new bias
    clear_q();
    beat(10, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(20, 1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    c0 = cyc;
    beat(5, -1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    check_one("restart", 16, c0 + 4);

    // Back-to-back single-beat groups 1..4
    clear_q();
    c0 = cyc;
    for (int i = 1; i <= 4; i++) beat(i, 1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    chk("b2b count", 64'(vq.size()), 64'sd4);
    for (int i = 0; i < 4; i++)
      if (vq.size() > i) begin
        chk($sformatf("b2b%0d data", i), 64'(vq[i]), 64'(i + 1));
        chk($sformatf("b2b%0d cycle", i), 64'(cq[i]), 64'(c0 + 4 + i));
      end

    // Two beats of 33153 overflow the 16-bit accumulator
    clear_q();
    win = '0; weight = '0;
    win[0*DW +: DW] = 8'd255; weight[0*WW +: WW] = 8'sd127;
    win[1*DW +: DW] = 8'd255; weight[1*WW +: WW] = 8'sd3;
    win[2*DW +: DW] = 8'd3;   weight[2*WW +: WW] = 8'sd1;
    drive(1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    chk("sat count16", 64'(vq16.size()), 64'sd1);
    if (vq16.size() >= 1) begin
      chk("sat data16", 64'(vq16[0]), 64'sd32767);
      chk("sat flag16", 64'(sq16[0]), 64'sd1);
    end
    chk("sat count32", 64'(vq.size()), 64'sd1);
    if (vq.size() >= 1) begin
      chk("sat data32", 64'(vq[0]), 64'sd66306);
      chk("sat flag32", 64'(sq[0]), 64'sd0);
    end

    // Next small group clears the sticky flag
    clear_q();
    beat(7, 1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    chk("post-sat count16", 64'(vq16.size()), 64'sd1);
    if (vq16.size() >= 1) begin
      chk("post-sat data16", 64'(vq16[0]), 64'sd7);
      chk("post-sat flag16", 64'(sq16[0]), 64'sd0);
    end

    // Reset with a complete group still in flight
    clear_q();
    beat(10, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(20, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'sd0);
    chk("midrst out_data", 64'(out_data), 64'sd0);
    chk("midrst out_sat", 64'(out_sat), 64'sd0);
    chk("midrst out_data16", 64'(out_data16), 64'sd0);
    repeat (3) idle_beat();
    chk("midrst no pulse", 64'(vq.size()), 64'sd0);
    rst = 1'b0;
    c0 = cyc;
    beat(7, 1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    check_one("after rst", 7, c0 + 4);

    // A last-only beat accumulates onto the current acc
    clear_q();
    c0 = cyc;
    beat(5, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (5) idle_beat();
    check_one("no first", 12, c0 + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_kxk_acc.md
# mac_kxk_acc

Parametrised, pipelined K×K convolution MAC with multi-channel accumulation, bias, saturation and optional ReLU. It accepts one K×K unsigned pixel window and signed weight set per cycle. It accumulates the window dot-products across a framed group of beats, one beat per input channel, and emits one post-processed result per group. It sits between the line-buffer/window generator and the output quantiser, and replaces the fixed 3×3 single-channel MAC.

## Interface
- K, 3, kernel side; window has K*K taps, K ≥ 1
- DW, 8, unsigned pixel width
- WW, 8, signed weight width
- ACCW, 32, signed accumulator/output width; must be ≥ DW+WW+1+clog2(K*K)
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  beat valid
- in_first  in  1  first beat of a group; qualified by in_valid
- in_last  in  1  last beat of a group; qualified by in_valid
- win  in  K*K*DW  unsigned pixels; tap (r,c) at bits [(r*K+c)*DW +: DW]
- weight  in  K*K*WW  signed weights; same tap ordering
- bias  in  ACCW  signed bias; sampled on the in_first beat
- relu_en  in  1  clamp negative results to 0; sampled on the in_last beat
- out_valid  out  1  one-cycle pulse per completed group
- out_data  out  ACCW  signed result; holds its value until the next out_valid
- out_sat  out  1  saturation occurred anywhere in the group; valid with out_valid

## Operation
- Each product = $signed({1'b0,pix}) * $signed(w), width PW = DW+1+WW, exact.
- Per-row sum of K products at width PW+clog2(K). Total of K rows at width SW = PW+clog2(K*K), sign-extended to ACCW.
- Accumulator update at the stage-4 beat:
  - in_first set: acc ← sat(bias + S).
  - in_first clear: acc ← sat(acc + S).
  - sat clamps to [-2^(ACCW-1), 2^(ACCW-1)-1].
  - Clamping sets a sticky sat flag. in_first clears the flag and then applies this beat's saturation.
- in_last beat: out_data ← (relu_en && result<0) ? 0 : result, where result is the post-update acc. out_sat ← sticky flag. out_valid ← 1.
- in_first and in_last on the same beat form a single-beat group: out = relu(sat(bias+S)).
- A beat with in_first clear and no prior group accumulates onto the current acc. acc is 0 after reset.
- in_first mid-group discards the partial group silently and emits no output for it.
- in_valid low: the beat is a bubble. Flags are ignored and acc is unchanged. Bubbles may appear anywhere inside a group.
- No backpressure. The block accepts a beat every cycle.

## Timing
- 4-stage pipeline:
  - S1 registers products.
  - S2 registers row sums.
  - S3 registers the total S.
  - S4 registers acc, out_data, out_valid.
- valid, first, last, bias and relu_en travel alongside the data in the pipeline.
- Latency: a beat presented at edge n with in_last=1 gives out_valid=1 after edge n+4.
- Throughput: 1 beat/cycle. Back-to-back single-beat groups produce out_valid on consecutive cycles.
- Reset (asynchronous assert, at any time) drives to 0: all pipeline valid bits, acc, sticky flag, out_valid, out_data, out_sat.
- Reset during a group drops all in-flight beats; no output is produced for them.
- After reset deasserts, the first in_valid beat is accepted on the next edge.

## Structure
- Package mac_pkg holds:
  - function clog2.
  - functions computing PW and SW from K/DW/WW.
  - function sat_add(a,b) returning {sat_flag, sum} at ACCW.
- Sub-module mac_row_k: K multipliers plus a row adder, registered products (S1) and registered row sum (S2). It is instantiated K times.
- Top level: S3 row tree, S4 accumulator/post-processing, sideband pipeline.

## Test plan
- K=3, all pixels 255, all weights -128, bias 0, single-beat group → out_data = -293760 at +4 cycles, out_sat=0.
- 3-beat group: beat totals 10, 20, -5, bias 100 → one out_valid only, on the last beat, out_data=125. A bubble inserted mid-group leaves the result unchanged.
- relu_en=1, single beat with total -50, bias 0 → out_data=0. Same stimulus with relu_en=0 → -50.
- ACCW=16, K=3, DW=8, WW=8: two beats of total 33153 → out_data=32767 and out_sat=1. The next group with small values has out_sat=0.
- Single-beat groups on consecutive cycles with totals 1,2,3,4 → out_valid high for 4 consecutive cycles with data 1,2,3,4.
- Assert rst mid-group, then release and send a single-beat group of total 7 → out_valid only for the new group, with out_data=7. All outputs read 0 during reset.
